cmos_merge_ctrl: RTL

- Sequencer for the dual-OV5640 side-by-side merge path: builds one 2*LINE_W output line from a live cmos0 line followed by a buffered cmos1 line.
- Drives write/read/reset of the cmos1 line FIFO and the output mux select.
- Generates merged href/de/vsync timing and error status.
- Sits between both sensor capture ports and the frame-buffer writer, in the cmos1_pclk domain.

---
 rtl/cmos_merge_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cmos_merge_ctrl.sv
// Side-by-side merge sequencer: a live cmos0 line followed by the buffered cmos1 line
// forms one 2*LINE_W output line. Drives the cmos1 line FIFO, the output mux and merged timing.
module cmos_merge_ctrl #(
  parameter int LINE_W       = 640,
  parameter int CNT_W        = 12,
  parameter int FIFO_RST_CYC = 4
) (
  input  logic             cmos1_pclk,
  input  logic             sys_rst_n,
  input  logic             cmos0_vsync,
  input  logic             cmos0_href,
  input  logic             cmos1_href,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic             fifo_rst,
  output logic             data_sel,
  output logic             pixel_vsync,
  output logic             pixel_href,
  output logic             pixel_de,
  output logic [CNT_W-1:0] line_cnt,
  output logic             ovf_err,
  output logic             line_err
);

  typedef enum logic [2:0] {IDLE, FRST, WAIT, LEFT, RIGHT} state_t;

  localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(LINE_W);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(FIFO_RST_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  state_t           state, state_nxt;
  logic             href0_p1;
  logic [CNT_W-1:0] left_cnt, left_nxt;
  logic [CNT_W-1:0] right_cnt, right_nxt;
  logic [CNT_W-1:0] rst_cnt, rst_cnt_nxt;
  logic [CNT_W-1:0] line_cnt_nxt;
  logic             fifo_wr_en_nxt, fifo_rst_nxt, data_sel_nxt;
  logic             pixel_href_nxt, pixel_de_nxt;
  logic             ovf_nxt, line_err_nxt;
  logic             vs_rise, href0_rise, right_busy;

  // pixel_vsync doubles as the previous-cycle vsync used for edge detection
  assign vs_rise    = cmos0_vsync & ~pixel_vsync;
  assign href0_rise = cmos0_href & ~href0_p1;
  assign right_busy = (right_cnt < LINE_LEN);
  // a colliding cmos0 line or a new frame cancels the read in the same cycle
  assign fifo_rd_en = (state == RIGHT) & ~fifo_empty & right_busy & ~href0_rise & ~vs_rise;

  always_comb begin
    state_nxt    = state;
    left_nxt     = left_cnt;
    right_nxt    = right_cnt;
    rst_cnt_nxt  = rst_cnt;
    line_cnt_nxt = line_cnt;
    line_err_nxt = line_err;
    ovf_nxt      = ovf_err | ((state != IDLE) & cmos1_href & fifo_full);
    pixel_de_nxt = 1'b0;
    fifo_rst_nxt = 1'b0;

    case (state)
      FRST: begin
        rst_cnt_nxt = rst_cnt + ONE;
        if (rst_cnt == RST_LAST) state_nxt = WAIT;
        else                     fifo_rst_nxt = 1'b1;
      end
      WAIT: begin
        if (cmos0_href) begin
          state_nxt    = LEFT;
          left_nxt     = ONE;
          pixel_de_nxt = 1'b1;
        end
      end
      LEFT: begin
        if (cmos0_href) begin
          left_nxt     = sat_inc(left_cnt);
          pixel_de_nxt = 1'b1;
        end else begin
          if (left_cnt != LINE_LEN) line_err_nxt = 1'b1;
          state_nxt = RIGHT;
          right_nxt = ZERO;
        end
      end
      RIGHT: begin
        if (fifo_rd_en) right_nxt = right_cnt + ONE;
        pixel_de_nxt = fifo_rd_en;
        if (href0_rise) begin
          // truncated line is flagged, a complete one still counts
          if (right_busy) line_err_nxt = 1'b1;
          else            line_cnt_nxt = sat_inc(line_cnt);
          state_nxt    = LEFT;
          left_nxt     = ONE;
          pixel_de_nxt = 1'b1;
        end else if (!right_busy) begin
          line_cnt_nxt = sat_inc(line_cnt);
          state_nxt    = WAIT;
        end
      end
      default: ;
    endcase

    if (vs_rise) begin
      state_nxt    = FRST;
      rst_cnt_nxt  = ZERO;
      left_nxt     = ZERO;
      right_nxt    = ZERO;
      line_cnt_nxt = ZERO;
      ovf_nxt      = 1'b0;
      line_err_nxt = 1'b0;
      fifo_rst_nxt = 1'b1;
      pixel_de_nxt = 1'b0;
    end

    fifo_wr_en_nxt = (state != IDLE) & cmos1_href & ~fifo_full & ~fifo_rst_nxt;
    pixel_href_nxt = (state_nxt == LEFT) | (state_nxt == RIGHT);
    data_sel_nxt   = (state_nxt == RIGHT);
  end

  // registered control and timing outputs, one cycle behind their inputs
  always_ff @(posedge cmos1_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      href0_p1    <= 1'b0;
      left_cnt    <= '0;
      right_cnt   <= '0;
      rst_cnt     <= '0;
      line_cnt    <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_rst    <= 1'b0;
      data_sel    <= 1'b0;
      pixel_vsync <= 1'b0;
      pixel_href  <= 1'b0;
      pixel_de    <= 1'b0;
      ovf_err     <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      href0_p1    <= cmos0_href;
      left_cnt    <= left_nxt;
      right_cnt   <= right_nxt;
      rst_cnt     <= rst_cnt_nxt;
      line_cnt    <= line_cnt_nxt;
      fifo_wr_en  <= fifo_wr_en_nxt;
      fifo_rst    <= fifo_rst_nxt;
      data_sel    <= data_sel_nxt;
      pixel_vsync <= cmos0_vsync;
      pixel_href  <= pixel_href_nxt;
      pixel_de    <= pixel_de_nxt;
      ovf_err     <= ovf_nxt;
      line_err    <= line_err_nxt;
    end
  end

endmodule
